// File: rtl/uart_rx_ctrl_if.sv
// Host-side receive handshake: one buffered byte with its error flags.
// The receiver drives it through the master modport and the consumer through the slave modport.
interface uart_rx_ctrl_if;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       Rx_ready;
  logic       Parity_error;
  logic       Frame_error;

  modport master (
    output Rx_data,
    output Rx_valid,
    output Parity_error,
    output Frame_error,
    input  Rx_ready
  );

  modport slave (
    input  Rx_data,
    input  Rx_valid,
    input  Parity_error,
    input  Frame_error,
    output Rx_ready
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit timing, 8 data + parity + stop, one-entry output buffer.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around every sample point, with all decisions one cycle later.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic        PARITY_ODD   = 1'b0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RxD,
  uart_rx_ctrl_if.master    rx_if,
  output logic              Overrun,
  output logic              Rx_idle
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t      state, state_n;
  logic        rxd_m, rxd_s;
  logic [CW-1:0] cnt;
  logic        strobe;
  logic        decide;
  logic        sample;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        par_err_r;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        perr_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        stop_dec;
  logic        handshake;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RxD;
      rxd_s <= rxd_m;
    end
  end

  // Strobe only inside a frame, so a wrap while idle can never pose as a sample point.
  always_comb begin
    strobe = 1'b0;
    unique case (state)
      START:              strobe = (cnt == CNT_HALF);
      DATA, PARITY, STOP: strobe = (cnt == CNT_LAST);
      default:            strobe = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (state == IDLE && !rxd_s) begin
      cnt <= '0;
    end else if (strobe || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] hist;
  logic       strobe_q;

  // hist holds the strobe-1 and strobe samples when the vote is taken at strobe+1.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hist     <= 2'b11;
      strobe_q <= 1'b0;
    end else begin
      hist     <= {hist[0], rxd_s};
      strobe_q <= strobe;
    end
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
  assign decide = strobe_q;
`else
  assign sample = rxd_s;
  assign decide = strobe;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    stop_dec  = 1'b0;
    handshake = valid_q & rx_if.Rx_ready;
    unique case (state)
      IDLE: begin
        if (!rxd_s) state_n = START;
      end
      START: begin
        if (decide) state_n = sample ? IDLE : DATA;
      end
      DATA: begin
        if (decide && bit_idx == 3'd7) state_n = PARITY;
      end
      PARITY: begin
        if (decide) state_n = STOP;
      end
      STOP: begin
        if (decide) begin
          stop_dec = 1'b1;
          state_n  = sample ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_idx   <= '0;
      shreg     <= '0;
      par_err_r <= 1'b0;
    end else begin
      if (state == START && decide) begin
        bit_idx <= '0;
      end
      if (state == DATA && decide) begin
        shreg   <= {sample, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == PARITY && decide) begin
        par_err_r <= sample ^ (^shreg) ^ PARITY_ODD;
      end
    end
  end

  // A load in the same cycle as a consume keeps Rx_valid high with no bubble.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (handshake) begin
        ovr_q <= 1'b0;
      end
      if (stop_dec) begin
        if (!valid_q || rx_if.Rx_ready) begin
          data_q  <= shreg;
          perr_q  <= par_err_r;
          ferr_q  <= ~sample;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.Rx_data      = data_q;
  assign rx_if.Rx_valid     = valid_q;
  assign rx_if.Parity_error = perr_q;
  assign rx_if.Frame_error  = ferr_q;
  assign Overrun            = ovr_q;
  assign Rx_idle            = (state == IDLE);

endmodule
